// File: rtl/i2cmb_mon_pkg.sv
// Shared types for the multi-bus I2C monitor: record kinds, the per-bus
// record layout, and the decoder state encoding.
package i2cmb_mon_pkg;

  typedef enum logic [1:0] {
    MON_START = 2'd0,
    MON_STOP  = 2'd1,
    MON_ADDR  = 2'd2,
    MON_DATA  = 2'd3
  } mon_kind_t;

  // Bus index is prepended to this record when it is merged into the FIFO.
  typedef struct packed {
    mon_kind_t  kind;
    logic [7:0] data_byte;
    logic       ack;
  } mon_rec_t;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_ADDR = 2'd1,
    DEC_DATA = 2'd2
  } dec_state_t;

  localparam int         REC_W         = $bits(mon_rec_t);
  localparam logic [3:0] BITS_PER_BYTE = 4'd8;

  function automatic mon_rec_t make_rec(input mon_kind_t  kind,
                                        input logic [7:0] data_byte,
                                        input logic       ack);
    mon_rec_t r;
    r.kind      = kind;
    r.data_byte = data_byte;
    r.ack       = ack;
    return r;
  endfunction

endpackage

// File: rtl/i2cmb_mon_decoder.sv
// Single-bus I2C decoder: synchronizes SCL/SDA, detects START/STOP and
// data bits, frames bytes with their ack, and holds one pending record
// until the merge arbiter takes it.
module i2cmb_mon_decoder
  import i2cmb_mon_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     scl_i,
  input  logic     sda_i,
  input  logic     enable_i,
  input  logic     take_i,
  output logic     pend_valid_o,
  output mon_rec_t pend_rec_o,
  output logic     err_set_o,
  output logic     drop_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  dec_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  // Set by the bit sampled on the current SCL high phase; that bit only
  // becomes real data once SCL falls. A START/STOP in the same high phase
  // means the rising edge was the condition's setup, not a data bit.
  logic       bit_open_q, bit_open_d;

  logic       pend_valid_q;
  mon_rec_t   pend_rec_q;

  logic       emit;
  mon_rec_t   emit_rec;
  logic       err_set;

  logic start_det, stop_det, scl_rise, scl_fall, scl_high, partial_byte;

  // Two-flop synchronizers plus previous-value registers, idling at bus-high.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign scl_high     = scl_sync_q & scl_prev_q;
  assign start_det    = scl_high & sda_prev_q & ~sda_sync_q;
  assign stop_det     = scl_high & ~sda_prev_q & sda_sync_q;
  assign scl_rise     = ~scl_prev_q & scl_sync_q;
  assign scl_fall     = scl_prev_q & ~scl_sync_q;
  assign partial_byte = bit_cnt_q > {3'b000, bit_open_q};

  // Decoder state, bit counter and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= DEC_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      bit_open_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      bit_open_q <= bit_open_d;
    end
  end

  // Next-state logic: framing, record emission and abort detection.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    bit_open_d = bit_open_q;
    emit       = 1'b0;
    emit_rec   = make_rec(MON_START, 8'h00, 1'b0);
    err_set    = 1'b0;

    if (scl_fall) bit_open_d = 1'b0;

    if (!enable_i) begin
      state_d    = DEC_IDLE;
      bit_cnt_d  = '0;
      bit_open_d = 1'b0;
    end else begin
      case (state_q)
        DEC_IDLE: begin
          if (start_det) begin
            emit       = 1'b1;
            emit_rec   = make_rec(MON_START, 8'h00, 1'b0);
            state_d    = DEC_ADDR;
            bit_cnt_d  = '0;
            bit_open_d = 1'b0;
          end
        end
        DEC_ADDR, DEC_DATA: begin
          if (start_det) begin
            emit       = 1'b1;
            emit_rec   = make_rec(MON_START, 8'h00, 1'b0);
            err_set    = partial_byte;
            state_d    = DEC_ADDR;
            bit_cnt_d  = '0;
            bit_open_d = 1'b0;
          end else if (stop_det) begin
            emit       = 1'b1;
            emit_rec   = make_rec(MON_STOP, 8'h00, 1'b0);
            err_set    = partial_byte;
            state_d    = DEC_IDLE;
            bit_cnt_d  = '0;
            bit_open_d = 1'b0;
          end else if (scl_rise) begin
            if (bit_cnt_q == BITS_PER_BYTE) begin
              // Ninth bit: ack is active-low on the wire.
              emit      = 1'b1;
              emit_rec  = make_rec((state_q == DEC_ADDR) ? MON_ADDR : MON_DATA,
                                   shift_q, ~sda_sync_q);
              bit_cnt_d = '0;
              state_d   = DEC_DATA;
            end else begin
              shift_d    = {shift_q[6:0], sda_sync_q};
              bit_cnt_d  = bit_cnt_q + 4'd1;
              bit_open_d = 1'b1;
            end
          end
        end
        default: state_d = DEC_IDLE;
      endcase
    end
  end

  // Pending slot: a new record overwrites, a grant empties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_rec_q   <= '0;
    end else if (emit) begin
      pend_valid_q <= 1'b1;
      pend_rec_q   <= emit_rec;
    end else if (take_i) begin
      pend_valid_q <= 1'b0;
    end
  end

  // A slot being granted this cycle is free for the new record.
  assign drop_o       = emit & pend_valid_q & ~take_i;
  assign err_set_o    = err_set;
  assign pend_valid_o = pend_valid_q;
  assign pend_rec_o   = pend_rec_q;

endmodule

// File: rtl/i2cmb_multi_bus_monitor.sv
// Multi-bus I2C monitor top: one decoder per bus, a round-robin merge into
// a first-word-fall-through record FIFO, sticky abort flags and a
// saturating lost-record counter.
module i2cmb_multi_bus_monitor
  import i2cmb_mon_pkg::*;
#(
  parameter int NUM_BUSES  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int BUS_ID_W   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_BUSES-1:0]   scl_i,
  input  logic [NUM_BUSES-1:0]   sda_i,
  input  logic [NUM_BUSES-1:0]   enable_i,
  output logic                   rec_valid_o,
  output logic [BUS_ID_W+10:0]   rec_data_o,
  input  logic                   rec_ready_i,
  output logic [NUM_BUSES-1:0]   err_o,
  input  logic                   err_clr_i,
  output logic [7:0]             drop_cnt_o
);

  localparam int REC_OUT_W = BUS_ID_W + REC_W;
  localparam int ADDR_W    = $clog2(FIFO_DEPTH);

  logic [NUM_BUSES-1:0] pend_valid, take, err_set, ow_drop;
  mon_rec_t             pend_rec [NUM_BUSES];

  for (genvar g = 0; g < NUM_BUSES; g++) begin : g_bus
    i2cmb_mon_decoder u_dec (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .scl_i       (scl_i[g]),
      .sda_i       (sda_i[g]),
      .enable_i    (enable_i[g]),
      .take_i      (take[g]),
      .pend_valid_o(pend_valid[g]),
      .pend_rec_o  (pend_rec[g]),
      .err_set_o   (err_set[g]),
      .drop_o      (ow_drop[g])
    );
  end

  logic [BUS_ID_W-1:0] ptr_q, ptr_d;
  logic                gnt_valid;
  logic [BUS_ID_W-1:0] gnt_idx;
  mon_rec_t            gnt_rec;
  int                  cand;

  logic [REC_OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 full, pop, wr_en, fifo_drop;

  logic [NUM_BUSES-1:0] err_q, err_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [5:0]           drop_sum;
  logic [8:0]           drop_total;

  // Round-robin search starting at the pointer; first pending bus wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_rec   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      cand = (int'(ptr_q) + i) % NUM_BUSES;
      if (!gnt_valid && pend_valid[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[BUS_ID_W-1:0];
        gnt_rec   = pend_rec[cand];
      end
    end
  end

  // One-hot take back to the granted decoder and the advanced pointer.
  always_comb begin
    take  = '0;
    ptr_d = ptr_q;
    if (gnt_valid) begin
      take[gnt_idx] = 1'b1;
      ptr_d = (gnt_idx == BUS_ID_W'(NUM_BUSES - 1)) ? '0 : gnt_idx + BUS_ID_W'(1);
    end
  end

  assign full        = (count_q == (ADDR_W + 1)'(FIFO_DEPTH));
  assign rec_valid_o = (count_q != '0);
  assign pop         = rec_valid_o & rec_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en       = gnt_valid & (~full | pop);
  assign fifo_drop   = gnt_valid & full & ~pop;

  // FIFO pointer and occupancy updates.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage.
  // NOTE: the array has no reset; occupancy is tracked by count_q and the
  // output is gated with rec_valid_o, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= {gnt_idx, gnt_rec};
  end

  assign rec_data_o = rec_valid_o ? mem_q[rd_ptr_q] : '0;

  // Lost records this cycle (slot overwrites plus full-FIFO drop), saturating.
  always_comb begin
    drop_sum = {5'd0, fifo_drop};
    for (int b = 0; b < NUM_BUSES; b++) begin
      drop_sum = drop_sum + {5'd0, ow_drop[b]};
    end
    drop_total = {1'b0, drop_cnt_q} + {3'b000, drop_sum};
    drop_cnt_d = drop_total[8] ? 8'hFF : drop_total[7:0];
  end

  // A new abort in the clear cycle takes precedence and keeps its bit.
  assign err_d = (err_q & ~{NUM_BUSES{err_clr_i}}) | err_set;

  // Arbiter pointer, sticky errors and drop counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      err_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_i2cmb_multi_bus_monitor.sv
// Directed bench for the multi-bus I2C monitor: bus-level I2C stimulus
// tasks push expected records into a queue, an independent monitor pops
// and compares every record the DUT hands out.
module tb_i2cmb_multi_bus_monitor;
  import i2cmb_mon_pkg::*;

  localparam int N   = 16;
  localparam int D   = 16;
  localparam int IDW = 4;
  localparam int RW  = IDW + 11;
  localparam int Q   = 40;  // quarter I2C bit period (4 clk)

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  scl = '1;
  logic [N-1:0]  sda = '1;
  logic [N-1:0]  enable = '1;
  logic          rec_ready = 1'b1;
  logic          err_clr = 1'b0;
  logic          rec_valid_o;
  logic [RW-1:0] rec_data_o;
  logic [N-1:0]  err_o;
  logic [7:0]    drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pops   = 0;
  logic [RW-1:0] exp_q[$];
  int            pop_cyc_q[$];
  logic [RW-1:0] mon_exp;

  i2cmb_multi_bus_monitor #(
    .NUM_BUSES (N),
    .FIFO_DEPTH(D),
    .BUS_ID_W  (IDW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda),
    .enable_i   (enable),
    .rec_valid_o(rec_valid_o),
    .rec_data_o (rec_data_o),
    .rec_ready_i(rec_ready),
    .err_o      (err_o),
    .err_clr_i  (err_clr),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int bus, input mon_kind_t k,
                                       input logic [7:0] b, input logic a);
    return {IDW'(bus), k, b, a};
  endfunction

  function automatic logic [7:0] d5(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Monitor: every handshake pops one expected record and compares it.
  always @(negedge clk) begin
    if (!rst && rec_valid_o && rec_ready) begin
      pops++;
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %0h, required none", rec_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("record", 32'(rec_data_o), 32'(mon_exp));
      end
    end
  end

  task automatic i2c_start(input int b);
    sda[b] = 1'b1; #Q;
    scl[b] = 1'b1; #Q;
    sda[b] = 1'b0; #Q;
    scl[b] = 1'b0; #Q;
  endtask

  task automatic i2c_stop(input int b);
    sda[b] = 1'b0; #Q;
    scl[b] = 1'b1; #Q;
    sda[b] = 1'b1; #Q;
  endtask

  task automatic i2c_bit(input int b, input logic v);
    sda[b] = v; #Q;
    scl[b] = 1'b1; #(2 * Q);
    scl[b] = 1'b0; #Q;
  endtask

  task automatic i2c_byte(input int b, input logic [7:0] v, input logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b, v[i]);
    i2c_bit(b, ~ack);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rec_ready = v;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
    repeat (10) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int p0;

    // Reset state.
    #23;
    check("reset_valid", rec_valid_o, 0);
    check("reset_data", rec_data_o, 0);
    check("reset_err", err_o, 0);
    check("reset_drop", drop_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: write 0x22, data 0xA5, on bus 3; START latency measured.
    exp_q.push_back(mk(3, MON_START, 8'h00, 1'b0));
    @(negedge clk);
    sda[3] = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rec_valid_o) break;
    end
    check("start_latency", lat, 4);
    #Q scl[3] = 1'b0;
    #Q;
    exp_q.push_back(mk(3, MON_ADDR, 8'h44, 1'b1));
    exp_q.push_back(mk(3, MON_DATA, 8'hA5, 1'b1));
    exp_q.push_back(mk(3, MON_STOP, 8'h00, 1'b0));
    i2c_byte(3, 8'h44, 1'b1);
    i2c_byte(3, 8'hA5, 1'b1);
    i2c_stop(3);
    wait_drain("t1_drain");

    // 2: read 0x5A with NACK, repeated START, STOP on bus 0.
    exp_q.push_back(mk(0, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(0, MON_ADDR, 8'h45, 1'b1));
    exp_q.push_back(mk(0, MON_DATA, 8'h5A, 1'b0));
    exp_q.push_back(mk(0, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(0, MON_STOP, 8'h00, 1'b0));
    i2c_start(0);
    i2c_byte(0, 8'h45, 1'b1);
    i2c_byte(0, 8'h5A, 1'b0);
    i2c_start(0);
    i2c_stop(0);
    wait_drain("t2_drain");
    check("t2_err", err_o, 0);

    // 3: STOP after 3 data bits on bus 7.
    exp_q.push_back(mk(7, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(7, MON_ADDR, 8'h20, 1'b1));
    exp_q.push_back(mk(7, MON_STOP, 8'h00, 1'b0));
    i2c_start(7);
    i2c_byte(7, 8'h20, 1'b1);
    i2c_bit(7, 1'b1);
    i2c_bit(7, 1'b0);
    i2c_bit(7, 1'b1);
    i2c_stop(7);
    wait_drain("t3_drain");
    check("t3_err_set", err_o, 32'h0080);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("t3_err_clr", err_o, 0);

    // Disabled bus: no records, no error.
    enable[2] = 1'b0;
    i2c_start(2);
    i2c_bit(2, 1'b1);
    i2c_stop(2);
    repeat (20) @(posedge clk);
    #1;
    check("disabled_valid", rec_valid_o, 0);
    check("disabled_err", err_o, 0);
    enable[2] = 1'b1;

    // 4: simultaneous START on buses 0, 5, 9 from a fresh arbiter pointer.
    do_reset();
    pop_cyc_q.delete();
    exp_q.push_back(mk(0, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(5, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(9, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(0, MON_STOP, 8'h00, 1'b0));
    exp_q.push_back(mk(5, MON_STOP, 8'h00, 1'b0));
    exp_q.push_back(mk(9, MON_STOP, 8'h00, 1'b0));
    @(negedge clk);
    sda[0] = 1'b0; sda[5] = 1'b0; sda[9] = 1'b0;
    #Q;
    scl[0] = 1'b0; scl[5] = 1'b0; scl[9] = 1'b0;
    #Q;
    scl[0] = 1'b1; scl[5] = 1'b1; scl[9] = 1'b1;
    #Q;
    sda[0] = 1'b1; sda[5] = 1'b1; sda[9] = 1'b1;
    #Q;
    wait_drain("t4_drain");
    check("t4_pops", pop_cyc_q.size(), 6);
    if (pop_cyc_q.size() >= 3) begin
      check("t4_gap01", pop_cyc_q[1] - pop_cyc_q[0], 1);
      check("t4_gap12", pop_cyc_q[2] - pop_cyc_q[1], 1);
    end

    // 5: 20 records on bus 1 with the reader stalled.
    set_ready(1'b0);
    exp_q.push_back(mk(1, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(1, MON_ADDR, 8'hA0, 1'b1));
    for (int i = 0; i < 14; i++) exp_q.push_back(mk(1, MON_DATA, d5(i), 1'b1));
    i2c_start(1);
    i2c_byte(1, 8'hA0, 1'b1);
    for (int i = 0; i < 17; i++) i2c_byte(1, d5(i), 1'b1);
    i2c_stop(1);
    repeat (10) @(posedge clk);
    #1;
    check("t5_drop", drop_cnt_o, 4);
    check("t5_valid", rec_valid_o, 1);
    check("t5_head", rec_data_o, mk(1, MON_START, 8'h00, 1'b0));
    p0 = pops;
    set_ready(1'b1);
    wait_drain("t5_drain");
    check("t5_count", pops - p0, 16);

    // 6: asynchronous reset in the middle of a byte on bus 4.
    set_ready(1'b0);
    exp_q.push_back(mk(4, MON_START, 8'h00, 1'b0));
    i2c_start(4);
    i2c_bit(4, 1'b1);
    i2c_bit(4, 1'b0);
    check("t6_pre_valid", rec_valid_o, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t6_rst_valid", rec_valid_o, 0);
    check("t6_rst_data", rec_data_o, 0);
    check("t6_rst_drop", drop_cnt_o, 0);
    scl[4] = 1'b1;
    sda[4] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_ready(1'b1);
    exp_q.push_back(mk(4, MON_START, 8'h00, 1'b0));
    exp_q.push_back(mk(4, MON_STOP, 8'h00, 1'b0));
    i2c_start(4);
    i2c_stop(4);
    wait_drain("t6_drain");
    check("t6_err", err_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
